mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one memory bus port between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RV64 pipeline.
- At most one transaction is outstanding on the bus at a time.
- MEM has priority over IF. A starvation counter guarantees IF forward progress.
- Sits between if_stage/mem_stage and the memory model.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- STARVE_MAX, 4, contended arbitrations IF may lose before it is forced to win (1..15)
- TIMEOUT, 255, bus response wait limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  IF request; held until if_gnt
- if_addr  in  ADDR_W  IF fetch address
- if_gnt  out  1  IF request accepted (combinational)
- if_rvalid  out  1  IF response pulse
- if_rdata  out  DATA_W  IF response data
- mem_req  in  1  MEM request; held until mem_gnt
- mem_addr  in  ADDR_W  MEM address
- mem_wen  in  1  1 = store, 0 = load
- mem_wdata  in  DATA_W  store data
- mem_wmask  in  8  store byte mask
- mem_gnt  out  1  MEM request accepted (combinational)
- mem_rvalid  out  1  MEM response/ack pulse
- mem_rdata  out  DATA_W  load data
- bus_req  out  1  bus request
- bus_addr  out  ADDR_W  bus address
- bus_wen  out  1  bus write enable
- bus_wdata  out  DATA_W  bus write data
- bus_wmask  out  8  bus byte mask
- bus_ready  in  1  bus accepts the request this cycle
- bus_rvalid  in  1  bus response valid
- bus_rdata  in  DATA_W  bus response data
- busy  out  1  state != IDLE
- err  out  1  timeout response pulse

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, owner=IF, starve_cnt=0.
  - All outputs 0, including bus_* and rdata.
  - A reset mid-transaction discards it. A bus_rvalid arriving later in IDLE is ignored.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req is present, select a winner and assert its gnt combinationally in this cycle.
  - Latch the winner's addr/wen/wdata/wmask into bus_* registers, record owner, and go to ISSUE.
  - For IF, bus_wen=0 and bus_wmask=0.
  - The requester may drop or change req from the next cycle.
- Selection:
  - Only MEM requesting -> MEM. Only IF requesting -> IF.
  - Both requesting: MEM, unless starve_cnt==STARVE_MAX, in which case IF wins.
  - On a contended MEM win, starve_cnt increments, saturating at STARVE_MAX.
  - Any IF grant clears starve_cnt.
- ISSUE: bus_req=1 and bus_* stable. When bus_ready=1, drop bus_req next cycle and go to WAIT.
- ISSUE/WAIT shortcut: if bus_rvalid=1 in the same cycle as bus_ready, capture the data and go directly to RESP.
- WAIT: on bus_rvalid=1, capture bus_rdata into the owner's rdata register and go to RESP.
- RESP:
  - The owner's rvalid=1 for exactly one cycle. rdata is held until the next response for that owner.
  - Stores also receive an rvalid ack; rdata then carries whatever bus_rdata returned.
  - Next state is IDLE. New arbitration happens in that IDLE cycle, giving 1 idle gap.
- Minimum latency, req to rvalid: 3 cycles (gnt in c0, bus_req in c1 with ready, data in c2 as WAIT captures, rvalid in c3).
- Requests arriving while busy are not granted; gnt=0 until IDLE.
- A bus_rvalid seen in IDLE or ISSUE without a prior bus_ready is ignored, except for the ISSUE shortcut above.

Optional Feature:
- Macro: MEM_PORT_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT without bus_rvalid, go to RESP with rdata=0 and err=1 for the RESP cycle.
  - A late bus_rvalid is then ignored.
- Undefined: no counter, WAIT lasts indefinitely, err tied to 0.

Test Plan:
- IF-only: if_req=1, addr=0x80000000; bus_ready=1 immediately; bus_rvalid=1 with 0x00100073 one cycle later -> if_gnt in c0, bus_req in c1, if_rvalid=1 with if_rdata=0x00100073 in c3, busy low in c4.
- MEM store: mem_req=1, wen=1, wdata=0x1122334455667788, wmask=0xFF -> bus_wen=1 and the same data/mask on the bus, mem_rvalid pulse, if_rvalid stays 0.
- Contention: if_req and mem_req held continuously with STARVE_MAX=4 -> grant order MEM,MEM,MEM,MEM,IF,MEM...
- bus_ready held low 5 cycles in ISSUE -> bus_req stays 1 with bus_addr stable. Stray bus_rvalid in IDLE -> no rvalid.
- rst asserted in WAIT -> all outputs 0 immediately. bus_rvalid the next cycle -> no response. Fresh if_req is granted normally.
- With MEM_PORT_ARB_TIMEOUT_EN and TIMEOUT=8, no bus_rvalid -> after 8 WAIT cycles: owner rvalid=1, rdata=0, err=1 for one cycle, then IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between IF and MEM; MEM has priority, a starvation counter bounds IF losses.
// Optional bus response timeout when MEM_PORT_ARB_TIMEOUT_EN is defined (err otherwise tied low).
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 64,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              mem_req,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_wen,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [7:0]        mem_wmask,
   output logic              mem_gnt,
   output logic              mem_rvalid,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              bus_req,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_wen,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [7:0]        bus_wmask,
   input  logic              bus_ready,
   input  logic              bus_rvalid,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              busy,
   output logic              err
);

   localparam int unsigned STARVE_W = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // Reject configurations the counters cannot represent.
   if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1) begin : g_param_chk
      $error("mem_port_arbiter: STARVE_MAX must be 1..15 and TIMEOUT >= 1");
   end

   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic [STARVE_W-1:0] r_starve;
   logic [STARVE_W-1:0] w_starve_nxt;
   logic                r_owner_mem;
   logic                w_if_win;
   logic                w_mem_win;
   logic                w_capture;
   logic                w_timeout;

   logic                r_bus_req;
   logic [ADDR_W-1:0]   r_bus_addr;
   logic                r_bus_wen;
   logic [DATA_W-1:0]   r_bus_wdata;
   logic [7:0]          r_bus_wmask;
   logic                r_if_rvalid;
   logic [DATA_W-1:0]   r_if_rdata;
   logic                r_mem_rvalid;
   logic [DATA_W-1:0]   r_mem_rdata;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_err;

   // Counts WAIT cycles; held at zero outside WAIT so every entry starts fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (r_state != ST_WAIT) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
   end
`endif

   // Next state, arbitration and starvation bookkeeping.
   always_comb begin
      w_state_nxt  = r_state;
      w_starve_nxt = r_starve;
      w_if_win     = 1'b0;
      w_mem_win    = 1'b0;
      w_capture    = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (if_req && (!mem_req || r_starve == STARVE_W'(STARVE_MAX))) begin
               w_if_win = 1'b1;
            end else if (mem_req) begin
               w_mem_win = 1'b1;
            end
            if (w_if_win) begin
               w_starve_nxt = '0;
            end else if (w_mem_win && if_req && r_starve < STARVE_W'(STARVE_MAX)) begin
               w_starve_nxt = r_starve + STARVE_W'(1);
            end
            if (w_if_win || w_mem_win) begin
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus_ready) begin
               if (bus_rvalid) begin
                  w_capture   = 1'b1;
                  w_state_nxt = ST_RESP;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (bus_rvalid) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_RESP;
            end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
            else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_RESP;
            end
`endif
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_starve <= w_starve_nxt;
      end
   end

   // Bus request latch, response capture and one-cycle rvalid pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner_mem  <= 1'b0;
         r_bus_req    <= 1'b0;
         r_bus_addr   <= '0;
         r_bus_wen    <= 1'b0;
         r_bus_wdata  <= '0;
         r_bus_wmask  <= '0;
         r_if_rvalid  <= 1'b0;
         r_if_rdata   <= '0;
         r_mem_rvalid <= 1'b0;
         r_mem_rdata  <= '0;
      end else begin
         r_if_rvalid  <= 1'b0;
         r_mem_rvalid <= 1'b0;
         if (w_if_win || w_mem_win) begin
            r_owner_mem <= w_mem_win;
            r_bus_req   <= 1'b1;
            r_bus_addr  <= w_mem_win ? mem_addr : if_addr;
            r_bus_wen   <= w_mem_win && mem_wen;
            r_bus_wdata <= w_mem_win ? mem_wdata : '0;
            r_bus_wmask <= w_mem_win ? mem_wmask : 8'h00;
         end
         if (r_state == ST_ISSUE && bus_ready) begin
            r_bus_req <= 1'b0;
         end
         if (w_capture || w_timeout) begin
            if (r_owner_mem) begin
               r_mem_rvalid <= 1'b1;
               r_mem_rdata  <= w_capture ? bus_rdata : '0;
            end else begin
               r_if_rvalid <= 1'b1;
               r_if_rdata  <= w_capture ? bus_rdata : '0;
            end
         end
      end
   end

`ifdef MEM_PORT_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_timeout;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   // Grants are combinational and suppressed while reset is asserted.
   assign if_gnt     = w_if_win && !rst;
   assign mem_gnt    = w_mem_win && !rst;
   assign if_rvalid  = r_if_rvalid;
   assign if_rdata   = r_if_rdata;
   assign mem_rvalid = r_mem_rvalid;
   assign mem_rdata  = r_mem_rdata;
   assign bus_req    = r_bus_req;
   assign bus_addr   = r_bus_addr;
   assign bus_wen    = r_bus_wen;
   assign bus_wdata  = r_bus_wdata;
   assign bus_wmask  = r_bus_wmask;
   assign busy       = (r_state != ST_IDLE);

endmodule
